// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: default parameters and width helper shared by the counter slice
package mod_counter_pkg;

    localparam int     DEF_WIDTH  = 8;
    localparam longint DEF_MODULO = 256;
    localparam int     DEF_DIV    = 1;
    localparam longint DEF_INIT   = 0;

    // Minimum of one bit so a DIV=1 prescaler still has a legal vector width
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler: divides enabled cycles by DIV and emits a combinational step tick
module tick_prescaler
    import mod_counter_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    // With DIV=1 LAST is zero, cnt never leaves zero and tick reduces to en
    assign tick = en && cnt == LAST;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + PW'(1);

endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with prescaler, load, clear, tc pulse and sticky ovf
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH  = DEF_WIDTH,
    parameter longint MODULO = DEF_MODULO,
    parameter int     DIV    = DEF_DIV,
    parameter longint INIT   = DEF_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT);

    logic             tick;
    logic             at_end;
    logic             at_zero;
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;

    tick_prescaler #(.DIV(DIV)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clear | load),
        .tick  (tick)
    );

    assign at_end  = out == MAXV;
    assign at_zero = out == '0;
    assign wrap    = tick && (up ? at_end : at_zero);
    assign nxt     = up ? (at_end ? '0 : out + WIDTH'(1)) : (at_zero ? MAXV : out - WIDTH'(1));
    assign ld      = load_val > MAXV ? MAXV : load_val;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out <= INITV;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clear) begin
            out <= INITV;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            out <= ld;
            tc  <= 1'b0;
        end else begin
            tc  <= wrap;
            ovf <= ovf | wrap;
            if (tick)
                out <= nxt;
        end

endmodule
